// File: rtl/strassen_pkg.sv
// Shared constants and types for the Strassen operand path.
// Holds the matrix geometry (N, IDX_W, DATA_W), the load and fetch state
// enums, and a small helper that checks whether an index is in range.
package strassen_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;   // log2(N): vector / lane address width
  localparam int unsigned CNT_W  = 11;  // byte counter width

  // Counter value of the final byte of one N x N matrix.
  localparam logic [CNT_W-1:0] LastByte = CNT_W'(N * N - 1);

  typedef enum logic [1:0] {
    LoadA,
    LoadB,
    Serve
  } load_state_e;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchCapture,
    FetchRespond,
    FetchGuard
  } fetch_state_e;

  // Requests outside the matrix return an all-zero vector.
  function automatic logic idx_in_range(logic [IDX_W-1:0] idx);
    return idx < IDX_W'(N);
  endfunction

endpackage

// File: rtl/operand_mem.sv
// 32x32 byte store for one operand matrix.
// Ports:
//   clk_i                 clock, rising edge
//   we_i                  write one byte this cycle
//   wr_vec_i, wr_lane_i   vector index and lane of the written byte
//   wr_data_i             byte to write
//   rd_en_i               load both read registers this cycle
//   rd_addr1_i/rd_addr2_i vector indices to read
//   rd_data1_o/rd_data2_o registered full vectors, element k in lane k
// Contents are deliberately not reset; they persist until overwritten.
module operand_mem import strassen_pkg::*; (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [ADDR_W-1:0]              wr_vec_i,
  input  logic [ADDR_W-1:0]              wr_lane_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic                           rd_en_i,
  input  logic [ADDR_W-1:0]              rd_addr1_i,
  input  logic [ADDR_W-1:0]              rd_addr2_i,
  output logic [N-1:0][DATA_W-1:0]       rd_data1_o,
  output logic [N-1:0][DATA_W-1:0]       rd_data2_o
);

  logic [N-1:0][DATA_W-1:0] mem_q [N];
  logic [N-1:0][DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [N-1:0][DATA_W-1:0] rd_data2_q, rd_data2_d;

  // Read registers only change when a read is requested.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (rd_en_i) begin
      rd_data1_d = mem_q[rd_addr1_i];
      rd_data2_d = mem_q[rd_addr2_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_vec_i][wr_lane_i] <= wr_data_i;
    end
    rd_data1_q <= rd_data1_d;
    rd_data2_q <= rd_data2_d;
  end

  assign rd_data1_o = rd_data1_q;
  assign rd_data2_o = rd_data2_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand loader and row/column fetch service for a matrix multiplier.
// Ports:
//   clk_in, rst_in        clock and asynchronous active-low reset
//   load_data/load_valid  byte stream: 1024 bytes of A (row-major) then 1024 of B
//   load_ready            byte accepted when load_valid is also high
//   restart_in            discard load progress and start a new load
//   complete              both matrices loaded, fetch service available
//   new_request           level request from the multiplier
//   row*_req, col*_req    requested A rows and B columns
//   matA_row*, matB_col*  returned vectors, element k in lane k
//   row*_in, col*_in      echo of the served indices
//   val_rows              one-cycle pulse, vectors and echoes valid
// A is stored by row and B by column so one memory read yields a full vector.
module operand_fetch import strassen_pkg::*; (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     restart_in,
  output logic                     complete,
  input  logic                     new_request,
  input  logic [IDX_W-1:0]         row1_req,
  input  logic [IDX_W-1:0]         row2_req,
  input  logic [IDX_W-1:0]         col1_req,
  input  logic [IDX_W-1:0]         col2_req,
  output logic [N-1:0][DATA_W-1:0] matA_row1,
  output logic [N-1:0][DATA_W-1:0] matA_row2,
  output logic [N-1:0][DATA_W-1:0] matB_col1,
  output logic [N-1:0][DATA_W-1:0] matB_col2,
  output logic [IDX_W-1:0]         row1_in,
  output logic [IDX_W-1:0]         row2_in,
  output logic [IDX_W-1:0]         col1_in,
  output logic [IDX_W-1:0]         col2_in,
  output logic                     val_rows
);

  load_state_e              load_state_q, load_state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     complete_q, complete_d;

  fetch_state_e             fetch_state_q, fetch_state_d;
  logic [IDX_W-1:0]         row1_idx_q, row1_idx_d;
  logic [IDX_W-1:0]         row2_idx_q, row2_idx_d;
  logic [IDX_W-1:0]         col1_idx_q, col1_idx_d;
  logic [IDX_W-1:0]         col2_idx_q, col2_idx_d;

  logic [N-1:0][DATA_W-1:0] a_row1_q, a_row1_d;
  logic [N-1:0][DATA_W-1:0] a_row2_q, a_row2_d;
  logic [N-1:0][DATA_W-1:0] b_col1_q, b_col1_d;
  logic [N-1:0][DATA_W-1:0] b_col2_q, b_col2_d;
  logic [IDX_W-1:0]         row1_in_q, row1_in_d;
  logic [IDX_W-1:0]         row2_in_q, row2_in_d;
  logic [IDX_W-1:0]         col1_in_q, col1_in_d;
  logic [IDX_W-1:0]         col2_in_q, col2_in_d;
  logic                     val_rows_q, val_rows_d;

  logic [N-1:0][DATA_W-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic                     byte_accept;
  logic                     a_we, b_we;
  logic                     serving;
  logic                     req_accept;
  logic [ADDR_W-1:0]        cnt_hi, cnt_lo;

  assign load_ready  = (load_state_q != Serve);
  // Restart wins over a byte presented in the same cycle.
  assign byte_accept = load_valid & load_ready & ~restart_in;
  assign a_we        = byte_accept & (load_state_q == LoadA);
  assign b_we        = byte_accept & (load_state_q == LoadB);
  assign cnt_hi      = cnt_q[2*ADDR_W-1:ADDR_W];  // k / 32: source row
  assign cnt_lo      = cnt_q[ADDR_W-1:0];         // k % 32: source column

  assign serving     = (load_state_q == Serve);
  assign req_accept  = serving & complete_q & (fetch_state_q == FetchIdle) &
                       new_request & ~restart_in;

  // A: vector = row, lane = column.
  operand_mem u_mem_a (
    .clk_i      (clk_in),
    .we_i       (a_we),
    .wr_vec_i   (cnt_hi),
    .wr_lane_i  (cnt_lo),
    .wr_data_i  (load_data),
    .rd_en_i    (req_accept),
    .rd_addr1_i (row1_req[ADDR_W-1:0]),
    .rd_addr2_i (row2_req[ADDR_W-1:0]),
    .rd_data1_o (a_rd1),
    .rd_data2_o (a_rd2)
  );

  // B: vector = column, lane = row (transposed on write).
  operand_mem u_mem_b (
    .clk_i      (clk_in),
    .we_i       (b_we),
    .wr_vec_i   (cnt_lo),
    .wr_lane_i  (cnt_hi),
    .wr_data_i  (load_data),
    .rd_en_i    (req_accept),
    .rd_addr1_i (col1_req[ADDR_W-1:0]),
    .rd_addr2_i (col2_req[ADDR_W-1:0]),
    .rd_data1_o (b_rd1),
    .rd_data2_o (b_rd2)
  );

  // Load sequencing.
  always_comb begin
    load_state_d = load_state_q;
    cnt_d        = cnt_q;
    if (restart_in) begin
      load_state_d = LoadA;
      cnt_d        = '0;
    end else if (byte_accept) begin
      if (cnt_q == LastByte) begin
        cnt_d        = '0;
        load_state_d = (load_state_q == LoadA) ? LoadB : Serve;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    complete_d = (load_state_d == Serve);
  end

  // Fetch sequencing. The memory read is launched on the accepting edge, so
  // the read data is ready in CAPTURE and lands in the output registers on
  // the CAPTURE -> RESPOND edge.
  always_comb begin
    fetch_state_d = fetch_state_q;
    row1_idx_d    = row1_idx_q;
    row2_idx_d    = row2_idx_q;
    col1_idx_d    = col1_idx_q;
    col2_idx_d    = col2_idx_q;
    a_row1_d      = a_row1_q;
    a_row2_d      = a_row2_q;
    b_col1_d      = b_col1_q;
    b_col2_d      = b_col2_q;
    row1_in_d     = row1_in_q;
    row2_in_d     = row2_in_q;
    col1_in_d     = col1_in_q;
    col2_in_d     = col2_in_q;
    val_rows_d    = 1'b0;
    if (restart_in) begin
      fetch_state_d = FetchIdle;
    end else if (serving) begin
      unique case (fetch_state_q)
        FetchIdle: begin
          if (req_accept) begin
            fetch_state_d = FetchCapture;
            row1_idx_d    = row1_req;
            row2_idx_d    = row2_req;
            col1_idx_d    = col1_req;
            col2_idx_d    = col2_req;
          end
        end
        FetchCapture: begin
          fetch_state_d = FetchRespond;
          a_row1_d      = idx_in_range(row1_idx_q) ? a_rd1 : '0;
          a_row2_d      = idx_in_range(row2_idx_q) ? a_rd2 : '0;
          b_col1_d      = idx_in_range(col1_idx_q) ? b_rd1 : '0;
          b_col2_d      = idx_in_range(col2_idx_q) ? b_rd2 : '0;
          row1_in_d     = row1_idx_q;
          row2_in_d     = row2_idx_q;
          col1_in_d     = col1_idx_q;
          col2_in_d     = col2_idx_q;
          val_rows_d    = 1'b1;
        end
        FetchRespond: begin
          fetch_state_d = FetchGuard;
        end
        // One dead cycle so the still-high level request is not re-taken.
        FetchGuard: begin
          fetch_state_d = FetchIdle;
        end
        default: begin
          fetch_state_d = FetchIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      load_state_q  <= LoadA;
      cnt_q         <= '0;
      complete_q    <= 1'b0;
      fetch_state_q <= FetchIdle;
      row1_idx_q    <= '0;
      row2_idx_q    <= '0;
      col1_idx_q    <= '0;
      col2_idx_q    <= '0;
      a_row1_q      <= '0;
      a_row2_q      <= '0;
      b_col1_q      <= '0;
      b_col2_q      <= '0;
      row1_in_q     <= '0;
      row2_in_q     <= '0;
      col1_in_q     <= '0;
      col2_in_q     <= '0;
      val_rows_q    <= 1'b0;
    end else begin
      load_state_q  <= load_state_d;
      cnt_q         <= cnt_d;
      complete_q    <= complete_d;
      fetch_state_q <= fetch_state_d;
      row1_idx_q    <= row1_idx_d;
      row2_idx_q    <= row2_idx_d;
      col1_idx_q    <= col1_idx_d;
      col2_idx_q    <= col2_idx_d;
      a_row1_q      <= a_row1_d;
      a_row2_q      <= a_row2_d;
      b_col1_q      <= b_col1_d;
      b_col2_q      <= b_col2_d;
      row1_in_q     <= row1_in_d;
      row2_in_q     <= row2_in_d;
      col1_in_q     <= col1_in_d;
      col2_in_q     <= col2_in_d;
      val_rows_q    <= val_rows_d;
    end
  end

  assign complete  = complete_q;
  assign matA_row1 = a_row1_q;
  assign matA_row2 = a_row2_q;
  assign matB_col1 = b_col1_q;
  assign matB_col2 = b_col2_q;
  assign row1_in   = row1_in_q;
  assign row2_in   = row2_in_q;
  assign col1_in   = col1_in_q;
  assign col2_in   = col2_in_q;
  assign val_rows  = val_rows_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch. Requests push an expected response
// computed from a plain array model of A and B; a monitor pops and compares
// whenever val_rows is seen.
module tb_operand_fetch;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       load_data;
  logic             load_valid;
  logic             load_ready;
  logic             restart_in;
  logic             complete;
  logic             new_request;
  logic [5:0]       row1_req, row2_req, col1_req, col2_req;
  logic [31:0][7:0] matA_row1, matA_row2, matB_col1, matB_col2;
  logic [5:0]       row1_in, row2_in, col1_in, col2_in;
  logic             val_rows;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .restart_in  (restart_in),
    .complete    (complete),
    .new_request (new_request),
    .row1_req    (row1_req),
    .row2_req    (row2_req),
    .col1_req    (col1_req),
    .col2_req    (col2_req),
    .matA_row1   (matA_row1),
    .matA_row2   (matA_row2),
    .matB_col1   (matB_col1),
    .matB_col2   (matB_col2),
    .row1_in     (row1_in),
    .row2_in     (row2_in),
    .col1_in     (col1_in),
    .col2_in     (col2_in),
    .val_rows    (val_rows)
  );

  typedef struct {
    logic [255:0] a1, a2, b1, b2;
    logic [5:0]   r1, r2, c1, c2;
    int           sample_edge;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] ref_a [32][32];   // ref_a[row][col]
  logic [7:0] ref_b [32][32];   // ref_b[row][col]
  int         cyc = 0;          // number of rising edges so far
  int         last_edge = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [255:0] row_vec(input int r);
    logic [255:0] v = '0;
    if (r < 32) for (int k = 0; k < 32; k++) v[k*8 +: 8] = ref_a[r][k];
    return v;
  endfunction

  function automatic logic [255:0] col_vec(input int c);
    logic [255:0] v = '0;
    if (c < 32) for (int k = 0; k < 32; k++) v[k*8 +: 8] = ref_b[k][c];
    return v;
  endfunction

  task automatic push_expect(input int sample_edge);
    exp_t e;
    e.a1 = row_vec(int'(row1_req));
    e.a2 = row_vec(int'(row2_req));
    e.b1 = col_vec(int'(col1_req));
    e.b2 = col_vec(int'(col2_req));
    e.r1 = row1_req;
    e.r2 = row2_req;
    e.c1 = col1_req;
    e.c2 = col2_req;
    e.sample_edge = sample_edge;
    exp_q.push_back(e);
  endtask

  // The consumer sees val_rows on the rising edge after this negedge,
  // which must be two edges after the request-sampling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && val_rows === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_val_rows: got val_rows=1 at edge %0d, expected no response", cyc + 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", 256'(cyc + 1), 256'(mon_e.sample_edge + 2));
        check("matA_row1", matA_row1, mon_e.a1);
        check("matA_row2", matA_row2, mon_e.a2);
        check("matB_col1", matB_col1, mon_e.b1);
        check("matB_col2", matB_col2, mon_e.b2);
        check("row1_in", 256'(row1_in), 256'(mon_e.r1));
        check("row2_in", 256'(row2_in), 256'(mon_e.r2));
        check("col1_in", 256'(col1_in), 256'(mon_e.c1));
        check("col2_in", 256'(col2_in), 256'(mon_e.c2));
      end
    end
  end

  task automatic set_rand_req();
    row1_req = 6'($urandom_range(0, 40));
    row2_req = 6'($urandom_range(0, 40));
    col1_req = 6'($urandom_range(0, 40));
    col2_req = 6'($urandom_range(0, 40));
  endtask

  // kind 0: A=r+c, B=r^c; kind 1: random bytes. req_at raises a request
  // just before that byte index is presented.
  task automatic load_bytes(input int kind, input int count, input bit gaps, input int req_at);
    int i = 0;
    int r, c;
    logic [7:0] b;
    while (i < count) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        @(posedge clk); #1;
      end else begin
        if (i < 1024) begin
          r = i / 32; c = i % 32;
          b = (kind == 0) ? 8'(r + c) : 8'($urandom);
          ref_a[r][c] = b;
        end else begin
          r = (i - 1024) / 32; c = (i - 1024) % 32;
          b = (kind == 0) ? 8'(r ^ c) : 8'($urandom);
          ref_b[r][c] = b;
        end
        if (i == req_at) begin
          set_rand_req();
          new_request = 1'b1;
        end
        load_data  = b;
        load_valid = 1'b1;
        if (i == 2047) begin
          check("ready_before_last", 256'(load_ready), 256'(1));
          check("complete_before_last", 256'(complete), 256'(0));
        end
        @(posedge clk); #1;
        i++;
      end
    end
    load_valid = 1'b0;
    last_edge  = cyc;
    if (count == 2048) begin
      check("ready_after_load", 256'(load_ready), 256'(0));
      check("complete_after_load", 256'(complete), 256'(1));
    end
  endtask

  task automatic await_resp(input bit hold_extra, input bit do_restart);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (val_rows === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL val_rows_timeout: got no val_rows in %0d cycles, expected one", n);
      if (exp_q.size() > 0) exp_q.delete(0);
      new_request = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (do_restart) begin
      restart_in = 1'b1;
      @(posedge clk); #1;
      restart_in  = 1'b0;
      new_request = 1'b0;
      check("restart_val_rows", 256'(val_rows), 256'(0));
      check("restart_complete", 256'(complete), 256'(0));
      check("restart_ready", 256'(load_ready), 256'(1));
    end else begin
      @(posedge clk); #1;
      if (hold_extra) begin
        @(posedge clk); #1;
      end
      new_request = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r1, input int r2, input int c1, input int c2, input bit hold);
    row1_req    = 6'(r1);
    row2_req    = 6'(r2);
    col1_req    = 6'(c1);
    col2_req    = 6'(c2);
    new_request = 1'b1;
    push_expect(cyc + 1);
    await_resp(hold, 1'b0);
  endtask

  task automatic issue_rand(input bit hold);
    set_rand_req();
    new_request = 1'b1;
    push_expect(cyc + 1);
    await_resp(hold, 1'b0);
  endtask

  task automatic restart_pulse();
    restart_in = 1'b1;
    @(posedge clk); #1;
    restart_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_val_rows"}, 256'(val_rows), 256'(0));
    check({tag, "_complete"}, 256'(complete), 256'(0));
    check({tag, "_matA_row1"}, matA_row1, 256'(0));
    check({tag, "_matA_row2"}, matA_row2, 256'(0));
    check({tag, "_matB_col1"}, matB_col1, 256'(0));
    check({tag, "_matB_col2"}, matB_col2, 256'(0));
    check({tag, "_echoes"}, 256'({row1_in, row2_in, col1_in, col2_in}), 256'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    load_data   = '0;
    load_valid  = 1'b0;
    restart_in  = 1'b0;
    new_request = 1'b0;
    row1_req    = '0;
    row2_req    = '0;
    col1_req    = '0;
    col2_req    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 256'(load_ready), 256'(1));

    // Deterministic load with load_valid held high.
    load_bytes(0, 2048, 1'b0, -1);
    issue(0, 17, 3, 31, 1'b0);
    issue(5, 40, 7, 63, 1'b0);
    for (int t = 0; t < 10; t++) issue_rand(1'($urandom_range(0, 1)));

    // Request raised while B is still loading must wait for complete.
    restart_pulse();
    load_bytes(1, 2048, 1'b1, 1500);
    push_expect(last_edge + 1);
    await_resp(1'b0, 1'b0);
    issue_rand(1'b0);

    // Restart in the RESPOND cycle, then reload and re-request.
    issue_rand(1'b0);
    set_rand_req();
    new_request = 1'b1;
    push_expect(cyc + 1);
    await_resp(1'b0, 1'b1);
    load_bytes(1, 2048, 1'b1, -1);
    issue_rand(1'b0);
    issue_rand(1'b1);

    // Restart together with a valid byte: the byte must be discarded.
    restart_pulse();
    load_bytes(1, 300, 1'b0, -1);
    restart_in = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    @(posedge clk); #1;
    restart_in = 1'b0;
    load_valid = 1'b0;
    check("restart_load_complete", 256'(complete), 256'(0));
    check("restart_load_ready", 256'(load_ready), 256'(1));
    load_bytes(1, 2048, 1'b1, -1);
    for (int t = 0; t < 3; t++) issue_rand(1'b0);

    // Reset pulse mid-load at byte 500.
    restart_pulse();
    load_bytes(1, 500, 1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midload_reset", 256'(load_ready), 256'(1));
    load_bytes(0, 2048, 1'b0, -1);
    issue(0, 17, 3, 31, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
